// File: rtl/dp32_if.sv
// Operand/result bundle for the dp32 SIMD multiply / dot-product unit.
// master drives the operands, slave returns the registered results.
interface dp32_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] mul_int32;
    logic [32:0] sum_int16;
    logic [17:0] sum_int8;
    logic [10:0] sum_int4;
    logic [7:0]  sum_int2;

    modport master (
        output a, b,
        input  mul_int32, sum_int16, sum_int8, sum_int4, sum_int2
    );

    modport slave (
        input  a, b,
        output mul_int32, sum_int16, sum_int8, sum_int4, sum_int2
    );
endinterface

// File: rtl/dp32.sv
// Unsigned SIMD multiply / dot-product unit: full 32x32 product plus 16/8/4/2-bit
// lane dot products, all registered with one cycle of latency.
module dp32 (
    input  logic    CLK,
    input  logic    nrst,
    dp32_if.slave   bus
);

    logic [3:0]  w_pd  [16];
    logic [3:0]  w_px1 [8];
    logic [3:0]  w_px2 [8];
    logic [7:0]  w_p4  [8];
    logic [15:0] w_p8  [4];
    logic [31:0] w_p16 [2];
    logic [63:0] w_mul;
    logic [32:0] w_s16;
    logic [17:0] w_s8;
    logic [10:0] w_s4;
    logic [7:0]  w_s2;

    logic [63:0] r_mul;
    logic [32:0] r_s16;
    logic [17:0] r_s8;
    logic [10:0] r_s4;
    logic [7:0]  r_s2;

    // 2-bit partial products; diagonal terms also feed the 4-bit lanes.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_pd[i] = {2'd0, bus.a[2*i +: 2]} * {2'd0, bus.b[2*i +: 2]};
        end
        for (int i = 0; i < 8; i++) begin
            w_px1[i] = {2'd0, bus.a[4*i+2 +: 2]} * {2'd0, bus.b[4*i +: 2]};
            w_px2[i] = {2'd0, bus.a[4*i +: 2]}   * {2'd0, bus.b[4*i+2 +: 2]};
        end
    end

    // Compose each 4-bit lane product from its four 2-bit partials.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_p4[i] = {w_pd[2*i+1], 4'd0}
                    + {1'b0, ({1'b0, w_px1[i]} + {1'b0, w_px2[i]}), 2'd0}
                    + {4'd0, w_pd[2*i]};
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_p8[i] = {8'd0, bus.a[8*i +: 8]} * {8'd0, bus.b[8*i +: 8]};
        end
        for (int i = 0; i < 2; i++) begin
            w_p16[i] = {16'd0, bus.a[16*i +: 16]} * {16'd0, bus.b[16*i +: 16]};
        end
        w_mul = {32'd0, bus.a} * {32'd0, bus.b};
    end

    // Lane reductions; accumulator widths are the exact worst-case widths.
    always_comb begin
        w_s2 = 8'd0;
        for (int i = 0; i < 16; i++) begin
            w_s2 = w_s2 + {4'd0, w_pd[i]};
        end
        w_s4 = 11'd0;
        for (int i = 0; i < 8; i++) begin
            w_s4 = w_s4 + {3'd0, w_p4[i]};
        end
        w_s8 = 18'd0;
        for (int i = 0; i < 4; i++) begin
            w_s8 = w_s8 + {2'd0, w_p8[i]};
        end
        w_s16 = {1'b0, w_p16[0]} + {1'b0, w_p16[1]};
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_mul <= 64'd0;
            r_s16 <= 33'd0;
            r_s8  <= 18'd0;
            r_s4  <= 11'd0;
            r_s2  <= 8'd0;
        end else begin
            r_mul <= w_mul;
            r_s16 <= w_s16;
            r_s8  <= w_s8;
            r_s4  <= w_s4;
            r_s2  <= w_s2;
        end
    end

    assign bus.mul_int32 = r_mul;
    assign bus.sum_int16 = r_s16;
    assign bus.sum_int8  = r_s8;
    assign bus.sum_int4  = r_s4;
    assign bus.sum_int2  = r_s2;

endmodule

// File: tb/tb_dp32.sv
// Directed, table-driven bench for dp32 with reset, pipelining and random-model checks.
module tb_dp32;

    logic clk;
    logic nrst;
    int   total;
    int   bad;

    dp32_if u_if ();

    dp32 u_dut (
        .CLK  (clk),
        .nrst (nrst),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] mul;
        logic [32:0] s16;
        logic [17:0] s8;
        logic [10:0] s4;
        logic [7:0]  s2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t v);
        chk({nm, ".mul_int32"}, u_if.mul_int32, v.mul);
        chk({nm, ".sum_int16"}, {31'd0, u_if.sum_int16}, {31'd0, v.s16});
        chk({nm, ".sum_int8"},  {46'd0, u_if.sum_int8},  {46'd0, v.s8});
        chk({nm, ".sum_int4"},  {53'd0, u_if.sum_int4},  {53'd0, v.s4});
        chk({nm, ".sum_int2"},  {56'd0, u_if.sum_int2},  {56'd0, v.s2});
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, output vec_t v);
        v.a   = a;
        v.b   = b;
        v.mul = 64'(a) * 64'(b);
        v.s16 = 33'd0;
        v.s8  = 18'd0;
        v.s4  = 11'd0;
        v.s2  = 8'd0;
        for (int i = 0; i < 2; i++)  v.s16 = v.s16 + 33'((a >> (16*i)) & 32'hFFFF) * 33'((b >> (16*i)) & 32'hFFFF);
        for (int i = 0; i < 4; i++)  v.s8  = v.s8  + 18'((a >> (8*i)) & 32'hFF) * 18'((b >> (8*i)) & 32'hFF);
        for (int i = 0; i < 8; i++)  v.s4  = v.s4  + 11'((a >> (4*i)) & 32'hF) * 11'((b >> (4*i)) & 32'hF);
        for (int i = 0; i < 16; i++) v.s2  = v.s2  + 8'((a >> (2*i)) & 32'h3) * 8'((b >> (2*i)) & 32'h3);
    endtask

    vec_t zero_v;
    vec_t rv;

    initial begin
        total = 0;
        bad   = 0;
        zero_v = '{32'd0, 32'd0, 64'd0, 33'd0, 18'd0, 11'd0, 8'd0};
        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 33'h1FFFC0002, 18'h3F804, 11'h708, 8'h90};
        vecs[1] = '{32'h22222222, 32'h22222222, 64'h048D159E1D950C84, 33'h091A1908, 18'h1210, 11'h020, 8'h20};
        vecs[2] = '{32'h11111111, 32'h11111111, 64'h0123456787654321, 33'h02468642, 18'h0484, 11'h008, 8'h08};
        vecs[3] = '{32'h55555555, 32'h55555555, 64'h1C71C71C38E38E39, 33'h38E31C72, 18'h70E4, 11'h0C8, 8'h10};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 64'h0, 33'h0, 18'h0, 11'h0, 8'h0};
        vecs[5] = '{32'h00000003, 32'h00000003, 64'h9, 33'h9, 18'h9, 11'h9, 8'h9};
        vecs[6] = '{32'h0000000C, 32'h0000000C, 64'h90, 33'h90, 18'h90, 11'h90, 8'h9};
        vecs[7] = '{32'h00030000, 32'h00020001, 64'h600030000, 33'h6, 18'h6, 11'h6, 8'h6};

        // Reset held with non-zero operands.
        nrst   = 1'b0;
        u_if.a = 32'hFFFFFFFF;
        u_if.b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset_hold", zero_v);
        u_if.a = 32'd0;
        u_if.b = 32'd0;
        nrst   = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_release_zero", zero_v);

        // Back-to-back table vectors: each result checked one edge after its input.
        for (int k = 0; k < 8; k++) begin
            u_if.a = vecs[k].a;
            u_if.b = vecs[k].b;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", k), vecs[k]);
        end

        // Output must not change before the next edge when inputs change.
        u_if.a = vecs[0].a;
        u_if.b = vecs[0].b;
        #2;
        chk_all("hold_between_edges", vecs[7]);
        @(posedge clk); #1;
        chk_all("after_edge", vecs[0]);

        // Asynchronous reset pulse between edges.
        #1 nrst = 1'b0;
        #1;
        chk_all("async_reset_immediate", zero_v);
        @(posedge clk); #1;
        chk_all("async_reset_held_edge", zero_v);
        u_if.a = vecs[3].a;
        u_if.b = vecs[3].b;
        #2 nrst = 1'b1;
        #1;
        chk_all("async_release_before_edge", zero_v);
        @(posedge clk); #1;
        chk_all("first_after_release", vecs[3]);

        // Random operands against a direct formula model.
        for (int k = 0; k < 20; k++) begin
            model($urandom, $urandom, rv);
            u_if.a = rv.a;
            u_if.b = rv.b;
            @(posedge clk); #1;
            chk_all($sformatf("rand%0d", k), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp32.md
Name: dp32

Overview:
- Unsigned SIMD multiply / dot-product unit on a pair of 32-bit operands.
- Each cycle it produces, in parallel:
  - the full 32x32 product;
  - dot products of the operands split into 16-, 8-, 4- and 2-bit lanes.
- Serves as the arithmetic core of the precision-scalable multiplier datapath.
- Outputs are registered; one clock, asynchronous active-low reset.

Parameters:
- none (all widths fixed)

Ports:
- CLK  input  1  clock; all outputs update on rising edge
- nrst  input  1  asynchronous active-low reset
- a  input  32  operand A, unsigned
- b  input  32  operand B, unsigned
- mul_int32  output  64  a*b, full unsigned product
- sum_int16  output  33  sum over i=0..1 of a[16i+15:16i]*b[16i+15:16i]
- sum_int8  output  18  sum over i=0..3 of a[8i+7:8i]*b[8i+7:8i]
- sum_int4  output  11  sum over i=0..7 of a[4i+3:4i]*b[4i+3:4i]
- sum_int2  output  8  sum over i=0..15 of a[2i+1:2i]*b[2i+1:2i]

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (CLK, nrst).
- Reset:
  - nrst low forces all five outputs to 0 immediately, independent of CLK.
  - Outputs hold 0 while nrst is low.
  - Reset deassertion is synchronised by normal edge sampling; the first valid result appears at the first rising edge with nrst high.
- Latency:
  - Exactly 1 cycle; inputs sampled on the rising edge, results visible after that edge.
  - Throughput is one operand pair per cycle.
  - No handshake and no valid signal.
- Arithmetic:
  - All lanes are unsigned.
  - Lane i occupies the same bit positions in a and b; lane 0 is the LSBs.
  - Output widths are exact maximum widths, so no overflow, truncation or wrap is possible:
    - 2*(2^16-1)^2 fits in 33 bits;
    - 4*255^2 = 260100 fits in 18 bits;
    - 8*225 = 1800 fits in 11 bits;
    - 16*9 = 144 fits in 8 bits.
  - All outputs are computed every cycle; there is no mode select.
- Implementation:
  - Free to share partial products between precisions, e.g. a 2-bit multiplier array reused for the coarser sums.
  - Must be bit-exact with the formulas above and meet 1-cycle latency.
- X/undriven inputs while out of reset may propagate; the bench drives known values before checking.
- Reset asserted mid-stream clears the outputs at once. The pipeline holds no other state.

Test Plan:
- Reset: nrst=0 with any a/b -> all outputs 0; release nrst, a=b=0 -> outputs stay 0.
- a=b=32'hFFFFFFFF -> after 1 edge:
  - mul_int32=64'hFFFFFFFE00000001
  - sum_int16=33'h1FFFC0002
  - sum_int8=18'h3F804
  - sum_int4=11'h708
  - sum_int2=8'h90
- a=b=32'h22222222 ->
  - mul_int32=64'h048D159E1D950C84
  - sum_int16=33'h091A1908
  - sum_int8=18'h1210
  - sum_int4=11'h020
  - sum_int2=8'h20
- a=b=32'h11111111 ->
  - mul_int32=64'h0123456787654321
  - sum_int16=33'h02468642
  - sum_int8=18'h0484
  - sum_int4=11'h008
  - sum_int2=8'h08
- a=b=32'h55555555 ->
  - mul_int32=64'h1C71C71C38E38E39
  - sum_int16=33'h38E31C72
  - sum_int8=18'h70E4
  - sum_int4=11'h0C8
  - sum_int2=8'h10
- Pipelining and async reset:
  - Apply the four vectors back-to-back on consecutive edges -> each result appears exactly one cycle after its input.
  - Pulse nrst low between edges -> outputs drop to 0 asynchronously, before the next edge.
